// File: rtl/integer_file_sb.sv
// integer_file_sb: register file with write-to-read forwarding, busy scoreboard and a sweep clear.
module integer_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk_in,
    input  logic                     reset_n_in,
    input  logic                     clr_in,
    output logic                     ready_out,
    input  logic [NUM_RD*ADDR_W-1:0] rs_addr_in,
    output logic [NUM_RD*DATA_W-1:0] rs_data_out,
    output logic [NUM_RD-1:0]        rs_busy_out,
    input  logic                     wr_en_in,
    input  logic [ADDR_W-1:0]        rd_addr_in,
    input  logic [DATA_W-1:0]        rd_in,
    input  logic                     iss_en_in,
    input  logic [ADDR_W-1:0]        iss_addr_in
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   idx, idx_nxt;
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              run, wr_ok, iss_ok;

    assign run       = state == RUN;
    assign ready_out = run;
    assign wr_ok     = run && !clr_in && wr_en_in && !(ZERO_REG != 0 && rd_addr_in == '0);
    assign iss_ok    = run && !clr_in && iss_en_in && !(ZERO_REG != 0 && iss_addr_in == '0);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        busy_nxt  = busy;
        if (!run) begin
            // the extra index bit flags completion after entry DEPTH-1
            idx_nxt   = idx + (ADDR_W+1)'(1);
            busy_nxt  = '0;
            state_nxt = idx_nxt[ADDR_W] ? RUN : CLEAR;
        end else if (clr_in) begin
            state_nxt = CLEAR;
            idx_nxt   = '0;
            busy_nxt  = '0;
        end else begin
            if (wr_ok)
                busy_nxt[rd_addr_in] = 1'b0;
            if (iss_ok)
                busy_nxt[iss_addr_in] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= CLEAR;
            idx   <= '0;
            busy  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            busy  <= busy_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!run)
            mem[idx[ADDR_W-1:0]] <= '0;
        else if (wr_ok)
            mem[rd_addr_in] <= rd_in;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              zero, fwd;
        assign a    = rs_addr_in[k*ADDR_W +: ADDR_W];
        assign zero = ZERO_REG != 0 && a == '0;
        assign fwd  = wr_en_in && a == rd_addr_in;
        assign rs_data_out[k*DATA_W +: DATA_W] = (!run || zero) ? '0 : fwd ? rd_in : mem[a];
        assign rs_busy_out[k] = (run && !zero && !fwd) ? busy[a] : 1'b0;
    end
endmodule

// File: doc/integer_file_sb.md
Name: integer_file_sb

Overview:
Parametrised integer register file for the pipelined core, with these features:
- configurable data width, depth and number of read ports;
- optional hardwired-zero register 0;
- same-cycle write-to-read forwarding;
- per-register busy scoreboard, set at issue and cleared at writeback.

Storage is cleared by a DEPTH-cycle sweep state machine after reset or on a soft clear. The decode stage reads operands and hazard status from this block; the writeback stage writes it.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes/issues

Ports:
clk_in  input  1  clock, all state on rising edge
reset_n_in  input  1  asynchronous active-low reset
clr_in  input  1  soft clear request, one-cycle pulse
ready_out  output  1  1 when in RUN state
rs_addr_in  input  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rs_data_out  output  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W]
rs_busy_out  output  NUM_RD  1 = the register read on port k has a pending producer
wr_en_in  input  1  writeback enable
rd_addr_in  input  ADDR_W  writeback address
rd_in  input  DATA_W  writeback data
iss_en_in  input  1  issue enable; marks the destination busy
iss_addr_in  input  ADDR_W  issue destination address

Behaviour:
Reset:
- Asserting reset_n_in low immediately sets state=CLEAR, sweep index=0, all busy bits=0.
- ready_out, rs_data_out and rs_busy_out are 0 while reset is asserted.
- Storage is not reset directly; the sweep clears it.

CLEAR state:
- Each cycle, writes 0 to entry[index], then increments index.
- After the cycle that writes entry DEPTH-1, the state becomes RUN; total DEPTH cycles from reset release.
- During CLEAR: ready_out=0; rs_data_out=0 and rs_busy_out=0 on all ports; wr_en_in, iss_en_in and clr_in are ignored; busy bits are held at 0.
- Reset asserted mid-sweep restarts the sweep at index 0.

RUN state:
- ready_out=1.
- clr_in=1: next state is CLEAR with index=0, all busy bits cleared. A write or issue presented in the same cycle is dropped.
- Write: when wr_en_in=1, entry[rd_addr_in] is updated to rd_in at the clock edge.

Read ports (combinational, zero latency), per port k, in priority order:
1. ZERO_REG=1 and address 0: data=0, busy=0.
2. wr_en_in=1 and address equals rd_addr_in: data=rd_in (forwarded), busy=0.
3. Otherwise: data=entry[address], busy=busy[address].
- Any number of ports may read the same address.

Scoreboard:
- Writeback with wr_en_in=1 clears busy[rd_addr_in] at the edge.
- Issue with iss_en_in=1 sets busy[iss_addr_in] at the edge.
- Issue and writeback to the same address in the same cycle: the set wins (a newer producer is in flight).
- Issue to an already-busy register keeps it busy (no count; a single outstanding producer per register is guaranteed by the issue stage).

Register 0 with ZERO_REG=1: writes and issues are ignored and forwarding is suppressed. With ZERO_REG=0, register 0 behaves like any other entry.

Width rules:
- No arithmetic on data.
- The sweep index is ADDR_W+1 bits so it can detect completion without wrap-around.

Test Plan:
- Reset release, hold all inputs 0 (defaults) -> ready_out=0 for exactly 32 cycles then 1; reading every address -> 0x00000000, busy=0.
- In RUN, write x5=0xDEADBEEF, next cycle read x5 on port 0 and port 1 -> both 0xDEADBEEF; same-cycle read of x7 while writing x7=0x12345678 -> port shows 0x12345678 before the edge.
- Write x0=0xFFFFFFFF with ZERO_REG=1 -> reads of x0 return 0 both during the write cycle and after; iss_en to x0 -> busy stays 0.
- Issue x3 -> busy on x3 reads 1 from the next cycle; writeback x3=0x1 -> busy 0 in the write cycle (forward) and after. Issue x4 and writeback x4 in the same cycle -> busy x4=1 afterwards.
- After several writes and issues, pulse clr_in together with wr_en_in to x9=0xAA -> write dropped, ready_out=0 for 32 cycles, all busy=0, all reads 0 after return to RUN.
- Assert reset_n_in at sweep index 10, release -> full 32-cycle sweep again; outputs 0 while asserted.
